// File: rtl/hexdisplay_ctrl.sv
// hexdisplay_ctrl: Avalon-MM slave driving up to 8 seven-segment digits.
// Per-digit hex decode or raw pattern, blanking, global enable and a common
// blink timer. out_port is registered and goes straight to the HEX pins.
// Optional build macro HEXDISPLAY_BYTEEN_EN adds a 4-bit byteenable port so
// writes to registers 0-6 update only the enabled byte lanes.
module hexdisplay_ctrl #(
  parameter int NUM_DIGITS = 8,
  parameter int BLINK_DIV  = 25000000,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [2:0]              address,
  input  logic                    chipselect,
  input  logic                    write_n,
  input  logic [31:0]             writedata,
`ifdef HEXDISPLAY_BYTEEN_EN
  input  logic [3:0]              byteenable,
`endif
  output logic [31:0]             readdata,
  output logic [7*NUM_DIGITS-1:0] out_port
);

  // One 7-bit lane per raw byte, only for digits that exist.
  function automatic logic [63:0] raw_mask_f();
    logic [63:0] m;
    m = '0;
    for (int i = 0; i < NUM_DIGITS; i++) m[8*i +: 7] = 7'h7F;
    return m;
  endfunction

  localparam int          CW       = $clog2(BLINK_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(BLINK_DIV - 1);
  localparam logic [7:0]  DIG_MASK = 8'hFF >> (8 - NUM_DIGITS);
  localparam logic [31:0] VAL_MASK = 32'hFFFF_FFFF >> (32 - 4*NUM_DIGITS);
  localparam logic [63:0] RAW_MASK = raw_mask_f();
  localparam logic [6:0]  RST_SEG  = ACTIVE_LOW ? 7'h40 : 7'h3F;
  localparam logic [31:0] ID_WORD  = {16'h4844, 12'h000, 4'(NUM_DIGITS)};

  // Hex decode, lit = 1, bit order g..a.
  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
      4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
      4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
      4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
    endcase
  endfunction

  logic [31:0]   value_q, value_d;
  logic [7:0]    mode_q, mode_d;
  logic [63:0]   raw_q, raw_d;
  logic [7:0]    blank_q, blank_d;
  logic [7:0]    blink_q, blink_d;
  logic          en_q, en_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          phase_q, phase_d;
  logic [7*NUM_DIGITS-1:0] out_q, out_d;

  logic        wr;
  logic        be_any;
  logic [31:0] be_mask;
  logic [31:0] merged;
  logic        blink_clr;

`ifdef HEXDISPLAY_BYTEEN_EN
  assign be_mask = {{8{byteenable[3]}}, {8{byteenable[2]}},
                    {8{byteenable[1]}}, {8{byteenable[0]}}};
  assign be_any  = |byteenable;
`else
  assign be_mask = 32'hFFFF_FFFF;
  assign be_any  = 1'b1;
`endif

  assign wr        = chipselect && !write_n && be_any;
  // Byte-lane merge against the current read view of the addressed register.
  assign merged    = (readdata & ~be_mask) | (writedata & be_mask);
  assign blink_clr = wr && (address == 3'd5);

  // Zero-latency read mux; unimplemented bits are stored as 0.
  always_comb begin
    readdata = '0;
    case (address)
      3'd0:    readdata = value_q;
      3'd1:    readdata = {24'h0, mode_q};
      3'd2:    readdata = raw_q[31:0];
      3'd3:    readdata = raw_q[63:32];
      3'd4:    readdata = {24'h0, blank_q};
      3'd5:    readdata = {24'h0, blink_q};
      3'd6:    readdata = {30'h0, phase_q, en_q};
      default: readdata = ID_WORD;
    endcase
  end

  // Register-file next state; ID writes fall through untouched.
  always_comb begin
    value_d = value_q;
    mode_d  = mode_q;
    raw_d   = raw_q;
    blank_d = blank_q;
    blink_d = blink_q;
    en_d    = en_q;
    if (wr) begin
      case (address)
        3'd0:    value_d       = merged & VAL_MASK;
        3'd1:    mode_d        = merged[7:0] & DIG_MASK;
        3'd2:    raw_d[31:0]   = merged & RAW_MASK[31:0];
        3'd3:    raw_d[63:32]  = merged & RAW_MASK[63:32];
        3'd4:    blank_d       = merged[7:0] & DIG_MASK;
        3'd5:    blink_d       = merged[7:0] & DIG_MASK;
        3'd6:    en_d          = merged[0];
        default: ;
      endcase
    end
  end

  // Blink timer: a BLINK write beats a simultaneous wrap.
  always_comb begin
    cnt_d   = cnt_q + 1'b1;
    phase_d = phase_q;
    if (blink_clr) begin
      cnt_d   = '0;
      phase_d = 1'b0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d   = '0;
      phase_d = !phase_q;
    end
  end

  // Per-digit pattern select, dark override, then pin polarity.
  always_comb begin
    out_d = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      logic [6:0] pat;
      pat = mode_q[i] ? raw_q[8*i +: 7] : hex7(value_q[4*i +: 4]);
      if (!en_q || blank_q[i] || (blink_q[i] && phase_q)) pat = '0;
      out_d[7*i +: 7] = ACTIVE_LOW ? ~pat : pat;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      value_q <= '0;
      mode_q  <= '0;
      raw_q   <= '0;
      blank_q <= '0;
      blink_q <= '0;
      en_q    <= 1'b1;
      cnt_q   <= '0;
      phase_q <= 1'b0;
      out_q   <= {NUM_DIGITS{RST_SEG}};
    end else begin
      value_q <= value_d;
      mode_q  <= mode_d;
      raw_q   <= raw_d;
      blank_q <= blank_d;
      blink_q <= blink_d;
      en_q    <= en_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      out_q   <= out_d;
    end
  end

  assign out_port = out_q;

endmodule

// File: tb/tb_hexdisplay_ctrl.sv
// Self-checking bench for hexdisplay_ctrl (NUM_DIGITS=8, BLINK_DIV=4, active-low).
// The reference model keeps per-digit state in arrays and derives the blink
// phase arithmetically from the number of edges since the last clear.
module tb_hexdisplay_ctrl;
  localparam int ND  = 8;
  localparam int DIV = 4;
`ifdef HEXDISPLAY_BYTEEN_EN
  localparam bit HAS_BE = 1'b1;
`else
  localparam bit HAS_BE = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [2:0]    address = '0;
  logic          chipselect = 1'b0;
  logic          write_n = 1'b1;
  logic [31:0]   writedata = '0;
  logic [3:0]    byteenable = 4'hF;
  logic [31:0]   readdata;
  logic [7*ND-1:0] out_port;

  int checks = 0;
  int errors = 0;

  hexdisplay_ctrl #(.NUM_DIGITS(ND), .BLINK_DIV(DIV), .ACTIVE_LOW(1'b1)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .address(address),
    .chipselect(chipselect),
    .write_n(write_n),
    .writedata(writedata),
`ifdef HEXDISPLAY_BYTEEN_EN
    .byteenable(byteenable),
`endif
    .readdata(readdata),
    .out_port(out_port)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [6:0] HEX [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                           7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  logic [3:0] m_val [ND];
  logic [6:0] m_raw [ND];
  logic [7:0] m_mode, m_blank, m_blink;
  logic       m_en;
  int         ecnt;       // rising edges since reset release
  int         clr_edge;   // edge index of last blink clear

  always @(posedge clk or negedge reset_n)
    if (!reset_n) ecnt <= 0;
    else          ecnt <= ecnt + 1;

  function automatic logic ph_at(int n);
    return (((n - clr_edge) / DIV) % 2) == 1;
  endfunction

  function automatic logic [7*ND-1:0] exp_out(logic ph);
    logic [7*ND-1:0] r;
    logic [6:0] p;
    r = '0;
    for (int i = 0; i < ND; i++) begin
      if (!m_en || m_blank[i] || (m_blink[i] && ph)) p = 7'h00;
      else if (m_mode[i]) p = m_raw[i];
      else p = HEX[m_val[i]];
      r[7*i +: 7] = ~p;
    end
    return r;
  endfunction

  function automatic logic [31:0] mread(int a);
    logic [31:0] r;
    r = '0;
    case (a)
      0: for (int i = 0; i < ND; i++) r[4*i +: 4] = m_val[i];
      1: r[7:0] = m_mode;
      2: for (int i = 0; i < 4; i++) if (i < ND) r[8*i +: 7] = m_raw[i];
      3: for (int i = 0; i < 4; i++) if (i + 4 < ND) r[8*i +: 7] = m_raw[i+4];
      4: r[7:0] = m_blank;
      5: r[7:0] = m_blink;
      6: r[1:0] = {ph_at(ecnt), m_en};
      default: r = {16'h4844, 12'h000, 4'(ND)};
    endcase
    return r;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < ND; i++) begin m_val[i] = '0; m_raw[i] = '0; end
    m_mode = '0; m_blank = '0; m_blink = '0; m_en = 1'b1; clr_edge = 0;
  endtask

  task automatic m_write(int a, logic [31:0] d, logic [3:0] be);
    logic [7:0] dm;
    dm = 8'hFF >> (8 - ND);
    case (a)
      0: for (int i = 0; i < ND; i++) if (be[i/2]) m_val[i] = d[4*i +: 4];
      1: if (be[0]) m_mode = d[7:0] & dm;
      2: for (int i = 0; i < 4; i++) if (i < ND && be[i]) m_raw[i] = d[8*i +: 7];
      3: for (int i = 0; i < 4; i++) if (i + 4 < ND && be[i]) m_raw[i+4] = d[8*i +: 7];
      4: if (be[0]) m_blank = d[7:0] & dm;
      5: begin
           if (be[0]) m_blink = d[7:0] & dm;
           if (be != 4'h0) clr_edge = ecnt;
         end
      6: if (be[0]) m_en = d[0];
      default: ;
    endcase
  endtask

  // ---------------- bus helpers (stimulus only) ----------------
  task automatic do_write(int a, logic [31:0] d, logic [3:0] be);
    address = 3'(a); writedata = d; byteenable = be;
    chipselect = 1'b1; write_n = 1'b0;
    @(posedge clk); #1;
    m_write(a, d, be);
    chipselect = 1'b0; write_n = 1'b1; byteenable = 4'hF;
  endtask

  task automatic rd(int a, output logic [31:0] d);
    address = 3'(a);
    #1 d = readdata;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [31:0] d;
    @(negedge clk);
    checks++;
    if (out_port !== {ND{7'h40}}) begin
      errors++; $display("FAIL reset_out got=%h exp=%h", out_port, {ND{7'h40}});
    end
    rd(7, d); checks++;
    if (d !== 32'h4844_0008) begin errors++; $display("FAIL reset_id got=%h exp=48440008", d); end
    rd(6, d); checks++;
    if (d !== 32'h1) begin errors++; $display("FAIL reset_ctrl got=%h exp=1", d); end
    for (int a = 0; a < 6; a++) begin
      rd(a, d); checks++;
      if (d !== 32'h0) begin errors++; $display("FAIL reset_reg%0d got=%h exp=0", a, d); end
    end
  endtask

  task automatic test_value();
    logic [7*ND-1:0] exp;
    logic [31:0] d;
    exp = {7'h40, 7'h40, 7'h40, 7'h40, 7'h08, 7'h12, 7'h0E, 7'h30};
    @(negedge clk);
    do_write(0, 32'h0000_A5F3, 4'hF);
    @(negedge clk); checks++;
    if (out_port !== {ND{7'h40}}) begin
      errors++; $display("FAIL value_early got=%h exp=%h", out_port, {ND{7'h40}});
    end
    @(negedge clk); checks++;
    if (out_port !== exp) begin errors++; $display("FAIL value_out got=%h exp=%h", out_port, exp); end
    rd(0, d); checks++;
    if (d !== 32'h0000_A5F3) begin errors++; $display("FAIL value_rd got=%h exp=0000a5f3", d); end
  endtask

  task automatic test_raw_blank_en();
    do_write(1, 32'h1, 4'hF);
    do_write(2, 32'h49, 4'hF);
    @(negedge clk); @(negedge clk); checks++;
    if (out_port[6:0] !== 7'h36) begin errors++; $display("FAIL raw_d0 got=%h exp=36", out_port[6:0]); end
    do_write(4, 32'h2, 4'hF);
    @(negedge clk); @(negedge clk); checks++;
    if (out_port[13:7] !== 7'h7F) begin errors++; $display("FAIL blank_d1 got=%h exp=7f", out_port[13:7]); end
    do_write(6, 32'h0, 4'hF);
    @(negedge clk); @(negedge clk); checks++;
    if (out_port !== {ND{7'h7F}}) begin errors++; $display("FAIL en_off got=%h exp=%h", out_port, {ND{7'h7F}}); end
    do_write(6, 32'h1, 4'hF);
    do_write(4, 32'h0, 4'hF);
    do_write(1, 32'h0, 4'hF);
    @(negedge clk); @(negedge clk); checks++;
    if (out_port !== exp_out(ph_at(ecnt - 1))) begin
      errors++; $display("FAIL restore got=%h exp=%h", out_port, exp_out(ph_at(ecnt - 1)));
    end
  endtask

  task automatic test_blink();
    logic [31:0] d;
    bit found;
    do_write(5, 32'h1, 4'hF);
    @(negedge clk);
    for (int k = 0; k < 3 * DIV; k++) begin
      @(negedge clk); checks++;
      if (out_port !== exp_out(ph_at(ecnt - 1))) begin
        errors++; $display("FAIL blink_out cyc=%0d got=%h exp=%h", k, out_port, exp_out(ph_at(ecnt - 1)));
      end
      rd(6, d); checks++;
      if (d !== mread(6)) begin errors++; $display("FAIL blink_phase cyc=%0d got=%h exp=%h", k, d, mread(6)); end
    end
    // Land a BLINK write on the edge where the counter would wrap 0 -> 1 phase.
    found = 1'b0;
    for (int k = 0; k < 50 && !found; k++) begin
      @(negedge clk);
      if (((ecnt - clr_edge) % DIV) == DIV - 1 && !ph_at(ecnt)) found = 1'b1;
    end
    checks++;
    if (!found) begin errors++; $display("FAIL wrap_wait got=timeout exp=wrap"); end
    do_write(5, 32'h1, 4'hF);
    rd(6, d); checks++;
    if (d[1] !== 1'b0) begin errors++; $display("FAIL wrap_clear got=%b exp=0", d[1]); end
    for (int k = 0; k < 2 * DIV; k++) begin
      @(negedge clk);
      rd(6, d); checks++;
      if (d !== mread(6)) begin errors++; $display("FAIL post_clear cyc=%0d got=%h exp=%h", k, d, mread(6)); end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    @(negedge clk);
    do_write(0, 32'h1234_5678, 4'hF);
    do_write(0, 32'h9ABC_DEF0, 4'hF);
    @(negedge clk); @(negedge clk); checks++;
    if (out_port !== exp_out(ph_at(ecnt - 1))) begin
      errors++; $display("FAIL b2b_out got=%h exp=%h", out_port, exp_out(ph_at(ecnt - 1)));
    end
    rd(0, d); checks++;
    if (d !== 32'h9ABC_DEF0) begin errors++; $display("FAIL b2b_rd got=%h exp=9abcdef0", d); end
  endtask

  task automatic test_random();
    logic [31:0] d, wd;
    logic [3:0] be;
    int a, ra;
    for (int n = 0; n < 80; n++) begin
      a  = $urandom_range(0, 7);
      wd = $urandom;
      be = HAS_BE ? 4'($urandom_range(0, 15)) : 4'hF;
      @(negedge clk);
      do_write(a, wd, be);
      @(negedge clk); @(negedge clk); checks++;
      if (out_port !== exp_out(ph_at(ecnt - 1))) begin
        errors++; $display("FAIL rand_out n=%0d got=%h exp=%h", n, out_port, exp_out(ph_at(ecnt - 1)));
      end
      ra = $urandom_range(0, 7);
      rd(ra, d); checks++;
      if (d !== mread(ra)) begin errors++; $display("FAIL rand_rd n=%0d a=%0d got=%h exp=%h", n, ra, d, mread(ra)); end
    end
  endtask

  task automatic test_byteen();
    logic [31:0] d;
    @(negedge clk);
    do_write(0, 32'h0, 4'hF);
    do_write(0, 32'hFFFF_FFFF, 4'b0010);
    rd(0, d); checks++;
    if (d !== 32'h0000_FF00) begin errors++; $display("FAIL be_lane got=%h exp=0000ff00", d); end
    do_write(0, 32'h1234_5678, 4'b0000);
    rd(0, d); checks++;
    if (d !== 32'h0000_FF00) begin errors++; $display("FAIL be_none got=%h exp=0000ff00", d); end
  endtask

  task automatic test_async_reset();
    logic [31:0] d;
    @(negedge clk);
    do_write(6, 32'h1, 4'hF);
    do_write(0, 32'h89AB_CDEF, 4'hF);
    do_write(5, 32'hFF, 4'hF);
    repeat (6) @(negedge clk);
    @(posedge clk); #3;
    reset_n = 1'b0;
    #1;
    m_reset();
    checks++;
    if (out_port !== {ND{7'h40}}) begin errors++; $display("FAIL arst_out got=%h exp=%h", out_port, {ND{7'h40}}); end
    for (int a = 0; a < 7; a++) begin
      rd(a, d); checks++;
      if (d !== mread(a)) begin errors++; $display("FAIL arst_reg%0d got=%h exp=%h", a, d, mread(a)); end
    end
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (out_port !== exp_out(ph_at(ecnt - 1))) begin
      errors++; $display("FAIL arst_after got=%h exp=%h", out_port, exp_out(ph_at(ecnt - 1)));
    end
  endtask

  initial begin
    m_reset();
    #22 reset_n = 1'b1;
    test_reset();
    test_value();
    test_raw_blank_en();
    test_blink();
    test_back_to_back();
    test_random();
    if (HAS_BE) test_byteen();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hexdisplay_ctrl.md
Name: hexdisplay_ctrl

Overview:
- Avalon-MM slave that drives up to 8 seven-segment digits from a small register file.
- Replaces the single 32-bit raw-segment output register.
- Adds per-digit hex decode or raw mode, blanking, and a common blink timer.
- Sits on the PCIe-to-Avalon fabric; out_port goes straight to the board HEX pins.

Parameters:
- NUM_DIGITS, 8, number of digits driven; legal range 1..8.
- BLINK_DIV, 25000000, clk cycles per blink half-period; must be >= 2.
- ACTIVE_LOW, 1, 1 = segment lit when its bit is 0 (DE2 style); 0 = lit when 1.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  reset.
- address  in  3  word address.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data.
- readdata  out  32  read data, zero-latency (combinational from address and registers).
- out_port  out  7*NUM_DIGITS  segments; digit i occupies bits [7i+6:7i], bit order g..a (a = LSB).

Behaviour:
- Interface: reset reset_n, asynchronous, active-low; clock clk.
- Write condition: chipselect && !write_n; the register updates on the next rising clk edge.
- Register map (bits at or above NUM_DIGITS, or above 4*NUM_DIGITS for VALUE, are write-ignored and read as 0):
  - 0 VALUE: nibble per digit, digit i = bits [4i+3:4i]. Reset 0.
  - 1 MODE: bit i = 1 selects raw mode for digit i; 0 selects hex decode. Reset 0.
  - 2 RAW_LO: raw 7-bit pattern per byte, digits 0-3, byte i bits [6:0]; bit 7 of each byte reads 0. Reset 0.
  - 3 RAW_HI: same layout, digits 4-7. Reset 0.
  - 4 BLANK: bit i = 1 forces digit i dark. Reset 0.
  - 5 BLINK: bit i = 1 makes digit i blink.
    - Reset 0.
    - Any write also clears the blink counter and the blink phase.
  - 6 CTRL:
    - bit0 EN: global enable, reset 1; EN = 0 forces all digits dark.
    - bit1 PHASE: read-only current blink phase.
  - 7 ID: read-only.
    - bits [3:0] = NUM_DIGITS.
    - bits [31:16] = 0x4844.
    - Writes ignored.
- Raw patterns are stored as "lit = 1" in all modes; polarity is applied only at out_port.
- Hex decode table (lit = 1, g..a):
  - 0 3F, 1 06, 2 5B, 3 4F, 4 66, 5 6D, 6 7D, 7 07.
  - 8 7F, 9 6F, A 77, b 7C, C 39, d 5E, E 79, F 71.
- Digit dark = pattern 0 (lit = 1 form). It applies when any of these holds:
  - !EN;
  - BLANK[i];
  - BLINK[i] && PHASE.
- out_port is registered.
  - Each digit = ACTIVE_LOW ? ~pattern : pattern.
  - A register write is visible on out_port exactly 1 cycle after the write edge, i.e. 2 edges after write is sampled.
  - At reset out_port holds the decoded '0' on every digit: 0x40 per digit with ACTIVE_LOW = 1.
- Blink counter:
  - Counts 0..BLINK_DIV-1 every cycle, regardless of EN.
  - At BLINK_DIV-1 it wraps to 0 and toggles PHASE.
  - Reset: counter 0, PHASE 0.
- Simultaneous events: a write to BLINK on the same cycle as the counter wrap → the clear wins (counter 0, PHASE 0).
- Reads are side-effect free.
- Asserting reset_n low mid-operation → every register, the counter and out_port return to their reset values immediately, without waiting for a clk edge.

Optional Feature:
- Macro HEXDISPLAY_BYTEEN_EN.
- Defined:
  - Adds port byteenable (in, 4 bits).
  - Writes update only byte lanes whose enable bit is 1, for registers 0-6.
  - byteenable = 0 makes the write a no-op.
- Undefined:
  - No byteenable port.
  - Every write updates the full 32-bit word.

Test Plan:
1. Release reset, no writes → out_port = 0x40 on all 8 digits; read ID = 0x48440008; CTRL reads 0x1.
2. Write VALUE = 0x0000A5F3 → one cycle after the write edge:
   - digit0 = ~0x4F & 0x7F = 0x30;
   - digit1 = 0x0E, digit2 = 0x12, digit3 = 0x08;
   - digits 4-7 = 0x40.
3. Write MODE = 0x01 and RAW_LO = 0x00000049 → digit0 = 0x36; write BLANK = 0x02 → digit1 = 0x7F; write CTRL = 0 → all digits 0x7F.
4. BLINK_DIV = 4, write BLINK = 0x01:
   - digit0 toggles between its pattern and 0x7F every 4 cycles;
   - a BLINK write issued on the wrap cycle leaves PHASE = 0 and the counter = 0.
5. Assert reset_n mid-blink with a nonzero VALUE → all digits 0x40 asynchronously, all registers back to reset values.
6. With HEXDISPLAY_BYTEEN_EN defined:
   - write VALUE = 0xFFFFFFFF with byteenable = 0b0010 → VALUE reads 0x0000FF00;
   - write with byteenable = 0 → VALUE unchanged.
